// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory bridge: FSM encoding, store
// formats, and the byte-enable / lane-replication rules used on the RAM side.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic [1:0] FMT_WORD = 2'b00;
  localparam logic [1:0] FMT_HALF = 2'b01;
  localparam logic [1:0] FMT_BYTE = 2'b10;
  localparam logic [1:0] FMT_RSVD = 2'b11;

  function automatic logic [3:0] be_gen(input logic [1:0] fmt, input logic [1:0] off);
    case (fmt)
      FMT_WORD: be_gen = 4'b1111;
      FMT_HALF: be_gen = off[1] ? 4'b1100 : 4'b0011;
      FMT_BYTE: be_gen = 4'b0001 << off;
      default:  be_gen = 4'b0000;
    endcase
  endfunction

  // Replicate the right-justified store data into every lane it could target,
  // so the byte enables alone select the destination.
  function automatic logic [31:0] lane_rep(input logic [1:0] fmt, input logic [31:0] data);
    case (fmt)
      FMT_WORD: lane_rep = data;
      FMT_HALF: lane_rep = {data[15:0], data[15:0]};
      FMT_BYTE: lane_rep = {4{data[7:0]}};
      default:  lane_rep = 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_req_check.sv
// Combinational request validation: strobe exclusivity, reserved format,
// alignment and address range, plus the RAM word index of the address.
module dmem_req_check
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0000,
  parameter int          DEPTH_LOG2 = 11
) (
  input  logic [31:0]           addr,
  input  logic [1:0]            fmt,
  input  logic                  r,
  input  logic                  w,
  output logic                  ok,
  output logic [DEPTH_LOG2-1:0] word_idx
);

  localparam logic [32:0]           LIMIT     = {1'b0, BASE_ADDR} + (33'd4 << DEPTH_LOG2);
  localparam logic [DEPTH_LOG2-1:0] BASE_WORD = BASE_ADDR[DEPTH_LOG2+1:2];

  logic in_range;
  logic store_aligned;

  assign in_range = (addr >= BASE_ADDR) && ({1'b0, addr} < LIMIT);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    store_aligned = 1'b0;
    case (fmt)
      FMT_WORD: store_aligned = (addr[1:0] == 2'b00);
      FMT_HALF: store_aligned = (addr[0] == 1'b0);
      FMT_BYTE: store_aligned = 1'b1;
      default:  store_aligned = 1'b0;
    endcase
  end

  // Loads are always whole-word reads, so only stores care about format.
  assign ok       = (r ^ w) && in_range && (r || store_aligned);
  assign word_idx = addr[DEPTH_LOG2+1:2] - BASE_WORD;

endmodule

// File: rtl/dmem_bridge.sv
// Core-to-RAM data-memory bridge: validates load/store requests, drives a
// variable-latency single-port RAM with byte enables, and reports done/err.
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0000,
  parameter int          DEPTH_LOG2 = 11,
  parameter int          TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  dmem_r,
  input  logic                  dmem_w,
  input  logic [31:0]           data_addr,
  input  logic [31:0]           w_data,
  input  logic [1:0]            store_format_signal,
  output logic [31:0]           dmem_data,
  output logic [1:0]            detail_pos,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [DEPTH_LOG2-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ack
);

  localparam int               CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [31:0]             dmem_data_q;
  logic [1:0]              detail_pos_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    err_q;
  logic                    mem_en_q;
  logic                    mem_we_q;
  logic [DEPTH_LOG2-1:0]   mem_addr_q;
  logic [3:0]              mem_be_q;
  logic [31:0]             mem_wdata_q;

  logic                    req;
  logic                    req_ok;
  logic [DEPTH_LOG2-1:0]   req_idx;
  logic [3:0]              mem_be_d;
  logic [31:0]             mem_wdata_d;

  dmem_req_check #(
    .BASE_ADDR (BASE_ADDR),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_req_check (
    .addr    (data_addr),
    .fmt     (store_format_signal),
    .r       (dmem_r),
    .w       (dmem_w),
    .ok      (req_ok),
    .word_idx(req_idx)
  );

  assign req         = dmem_r | dmem_w;
  assign mem_be_d    = dmem_w ? be_gen(store_format_signal, data_addr[1:0]) : 4'b1111;
  assign mem_wdata_d = dmem_w ? lane_rep(store_format_signal, w_data) : 32'h0;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      dmem_data_q  <= 32'h0;
      detail_pos_q <= 2'b00;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= 4'b0000;
      mem_wdata_q  <= 32'h0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // The controller still holds its strobe during the err cycle; that
          // cycle is skipped so one bad request yields exactly one err pulse.
          if (req && !err_q) begin
            if (req_ok) begin
              state_q      <= ST_ACCESS;
              cnt_q        <= '0;
              detail_pos_q <= data_addr[1:0];
              busy_q       <= 1'b1;
              mem_en_q     <= 1'b1;
              mem_we_q     <= dmem_w;
              mem_addr_q   <= req_idx;
              mem_be_q     <= mem_be_d;
              mem_wdata_q  <= mem_wdata_d;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_ACCESS: begin
          if (mem_ack) begin
            if (!mem_we_q) dmem_data_q <= mem_rdata;
            state_q  <= ST_RESP;
            busy_q   <= 1'b0;
            mem_en_q <= 1'b0;
            done_q   <= 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            mem_en_q <= 1'b0;
            err_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dmem_data  = dmem_data_q;
  assign detail_pos = detail_pos_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: directed scenarios followed by random
// requests, all compared against an arithmetic reference model of the bridge.
module tb_dmem_bridge;

  localparam longint BASE       = 64'h1001_0000;
  localparam int     DEPTH_LOG2 = 11;
  localparam int     TIMEOUT    = 16;
  localparam longint SPAN_BYTES = 4 * (64'd1 << DEPTH_LOG2);

  logic                  clk = 1'b0;
  logic                  rstn;
  logic                  dmem_r;
  logic                  dmem_w;
  logic [31:0]           data_addr;
  logic [31:0]           w_data;
  logic [1:0]            store_format_signal;
  logic [31:0]           dmem_data;
  logic [1:0]            detail_pos;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic                  mem_en;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_addr;
  logic [3:0]            mem_be;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;
  logic                  mem_ack;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_dmem = 32'h0;
  logic [1:0]  exp_pos  = 2'b00;

  dmem_bridge #(
    .BASE_ADDR (32'h1001_0000),
    .DEPTH_LOG2(DEPTH_LOG2),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk                (clk),
    .rstn               (rstn),
    .dmem_r             (dmem_r),
    .dmem_w             (dmem_w),
    .data_addr          (data_addr),
    .w_data             (w_data),
    .store_format_signal(store_format_signal),
    .dmem_data          (dmem_data),
    .detail_pos         (detail_pos),
    .busy               (busy),
    .done               (done),
    .err                (err),
    .mem_en             (mem_en),
    .mem_we             (mem_we),
    .mem_addr           (mem_addr),
    .mem_be             (mem_be),
    .mem_wdata          (mem_wdata),
    .mem_rdata          (mem_rdata),
    .mem_ack            (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One controller transaction. waits < TIMEOUT: ack after that many idle
  // ACCESS cycles; waits >= TIMEOUT: the RAM never answers.
  task automatic run_req(input logic r, input logic w, input logic [31:0] addr,
                         input logic [31:0] data, input logic [1:0] fmt,
                         input int waits, input logic [31:0] rdata);
    longint      a;
    logic        ok;
    logic [31:0] exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_idx;
    int          en_cycles;

    a  = longint'(addr);
    ok = (r != w) && (a >= BASE) && (a < BASE + SPAN_BYTES);
    if (ok && w) begin
      if (fmt == 2'd0)      ok = (addr % 4 == 0);
      else if (fmt == 2'd1) ok = (addr % 2 == 0);
      else if (fmt == 2'd3) ok = 1'b0;
    end
    if (!w || fmt == 2'd0) exp_be = 15;
    else if (fmt == 2'd1)  exp_be = (addr % 4 == 0) ? 3 : 12;
    else                   exp_be = 1 << (addr % 4);
    if (fmt == 2'd0)      exp_wd = data;
    else if (fmt == 2'd1) exp_wd = (data % 65536) * 32'h0001_0001;
    else                  exp_wd = (data % 256) * 32'h0101_0101;
    exp_idx = 32'((a - BASE) / 4);

    dmem_r = r; dmem_w = w; data_addr = addr; w_data = data; store_format_signal = fmt;
    tick();

    if (!ok) begin
      check("rej_err", 32'(err), 1);
      check("rej_no_en", 32'(mem_en), 0);
      check("rej_pos_kept", 32'(detail_pos), 32'(exp_pos));
      tick();
      check("rej_err_single", 32'(err), 0);
      check("rej_no_en_later", 32'(mem_en), 0);
      dmem_r = 1'b0; dmem_w = 1'b0;
      return;
    end

    exp_pos = 2'(addr % 4);
    check("acc_en", 32'(mem_en), 1);
    check("acc_busy", 32'(busy), 1);
    check("acc_err", 32'(err), 0);
    check("acc_we", 32'(mem_we), 32'(w));
    check("acc_addr", 32'(mem_addr), exp_idx);
    check("acc_be", 32'(mem_be), exp_be);
    if (w) check("acc_wdata", mem_wdata, exp_wd);
    check("acc_pos", 32'(detail_pos), 32'(exp_pos));

    if (waits < TIMEOUT) begin
      for (int i = 0; i < waits; i++) begin
        data_addr = $urandom;
        tick();
        check("hold_en", 32'(mem_en), 1);
        check("hold_addr", 32'(mem_addr), exp_idx);
        check("hold_be", 32'(mem_be), exp_be);
      end
      mem_ack = 1'b1; mem_rdata = rdata;
      tick();
      mem_ack = 1'b0; mem_rdata = $urandom;
      if (r) exp_dmem = rdata;
      check("resp_done", 32'(done), 1);
      check("resp_err", 32'(err), 0);
      check("resp_busy", 32'(busy), 0);
      check("resp_en", 32'(mem_en), 0);
      check("resp_dmem", dmem_data, exp_dmem);
      check("resp_pos", 32'(detail_pos), 32'(exp_pos));
      dmem_r = 1'b0; dmem_w = 1'b0;
      tick();
      check("post_done", 32'(done), 0);
      check("post_no_en", 32'(mem_en), 0);
    end else begin
      en_cycles = 1;
      for (int k = 0; k < 3 * TIMEOUT; k++) begin
        data_addr = $urandom;
        tick();
        if (mem_en) en_cycles++;
        else break;
      end
      check("to_en_cycles", 32'(en_cycles), 32'(TIMEOUT));
      check("to_err", 32'(err), 1);
      check("to_done", 32'(done), 0);
      check("to_busy", 32'(busy), 0);
      check("to_dmem_kept", dmem_data, exp_dmem);
      tick();
      check("to_err_single", 32'(err), 0);
      check("to_no_en", 32'(mem_en), 0);
      dmem_r = 1'b0; dmem_w = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  fmt;
    logic        r;
    logic        w;
    int          waits;
    int          sel;

    rstn = 1'b0; dmem_r = 1'b0; dmem_w = 1'b0; data_addr = 32'h0; w_data = 32'h0;
    store_format_signal = 2'b00; mem_rdata = 32'h0; mem_ack = 1'b0;
    #12;
    check("rst_dmem", dmem_data, 0);
    check("rst_pos", 32'(detail_pos), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_en", 32'(mem_en), 0);
    check("rst_we", 32'(mem_we), 0);
    check("rst_be", 32'(mem_be), 0);
    rstn = 1'b1;
    tick();

    run_req(1'b0, 1'b1, 32'h1001_0008, 32'hCAFE_BABE, 2'b00, 2, 32'h0);
    run_req(1'b0, 1'b1, 32'h1001_0003, 32'h0000_00A5, 2'b10, 0, 32'h0);
    run_req(1'b1, 1'b0, 32'h1001_0003, 32'h0, 2'b00, 1, 32'hA511_2233);
    check("load_pos_3", 32'(detail_pos), 3);
    run_req(1'b0, 1'b1, 32'h1001_0001, 32'h1234, 2'b01, 0, 32'h0);
    run_req(1'b0, 1'b1, 32'h1000_FFFC, 32'h1, 2'b00, 0, 32'h0);
    run_req(1'b1, 1'b1, 32'h1001_0000, 32'h1, 2'b00, 0, 32'h0);
    run_req(1'b0, 1'b1, 32'h1001_0000, 32'h1, 2'b11, 0, 32'h0);
    run_req(1'b0, 1'b1, 32'h1001_2000, 32'h1, 2'b10, 0, 32'h0);
    run_req(1'b1, 1'b0, 32'h1001_1FFC, 32'h0, 2'b00, 0, 32'h0BAD_F00D);
    run_req(1'b1, 1'b0, 32'h1001_0010, 32'h0, 2'b00, TIMEOUT, 32'h0);
    run_req(1'b1, 1'b0, 32'h1001_0014, 32'h0, 2'b00, TIMEOUT - 1, 32'h1357_9BDF);
    run_req(1'b0, 1'b1, 32'h1001_0006, 32'hFFFF_BEEF, 2'b01, 0, 32'h0);

    // Asynchronous reset in the middle of an access.
    dmem_r = 1'b1; dmem_w = 1'b0; data_addr = 32'h1001_0020;
    tick();
    check("pre_rst_en", 32'(mem_en), 1);
    rstn = 1'b0;
    #1;
    exp_dmem = 32'h0; exp_pos = 2'b00;
    check("arst_en", 32'(mem_en), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_done", 32'(done), 0);
    check("arst_err", 32'(err), 0);
    check("arst_dmem", dmem_data, 0);
    check("arst_pos", 32'(detail_pos), 0);
    dmem_r = 1'b0;
    #1 rstn = 1'b1;
    tick();
    check("after_rst_idle", 32'(mem_en), 0);
    run_req(1'b1, 1'b0, 32'h1001_0024, 32'h0, 2'b00, 1, 32'h2468_ACE0);

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      addr = 32'h1001_0000 - 4 * $urandom_range(1, 4);
      else if (sel == 1) addr = 32'h1001_2000 + $urandom_range(0, 15);
      else if (sel == 2) addr = 32'h1001_1FFC;
      else               addr = 32'h1001_0000 + 4 * $urandom_range(0, 2047) + $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) addr = addr & 32'hFFFF_FFFC;
      sel = $urandom_range(0, 9);
      r = (sel == 0) || (sel < 5);
      w = (sel == 0) || (sel >= 5);
      fmt   = 2'($urandom_range(0, 3));
      data  = $urandom;
      waits = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT) : $urandom_range(0, 3);
      run_req(r, w, addr, data, fmt, waits, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Data-memory interface stage directly downstream of the multicycle CPU core.
- Takes the core's load/store strobes, byte address, store data and store format, and turns them into word-addressed accesses with byte enables on a single-ported RAM with variable latency (ack handshake).
- Returns the full aligned word for the core's MDR and holds the byte offset (detail_pos) for sub-word extraction.
- Adds alignment, range and timeout checking, with a busy/done handshake the controller stalls on.

Parameters:
- BASE_ADDR, 32'h1001_0000, byte address that maps to RAM word 0.
- DEPTH_LOG2, 11, log2 of RAM depth in 32-bit words.
- TIMEOUT, 16, maximum cycles to wait for mem_ack before aborting; must be >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- dmem_r  in  1  load request, sampled in IDLE.
- dmem_w  in  1  store request, sampled in IDLE.
- data_addr  in  32  byte address from the core.
- w_data  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- store_format_signal  in  2  00 word, 01 half, 10 byte, 11 reserved.
- dmem_data  out  32  last read word, aligned and unshifted.
- detail_pos  out  2  data_addr[1:0] of the last accepted request.
- busy  out  1  access in flight.
- done  out  1  one-cycle pulse when an access completes successfully.
- err  out  1  one-cycle pulse on a rejected or aborted access.
- mem_en  out  1  RAM request, held until acked.
- mem_we  out  1  write qualifier, valid while mem_en.
- mem_addr  out  DEPTH_LOG2  word address = (addr - BASE_ADDR) >> 2.
- mem_be  out  4  byte enables; bit i covers [8i+7:8i].
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  RAM read data, valid in the mem_ack cycle.
- mem_ack  in  1  RAM completion strobe.

Behaviour:
- Reset: all outputs 0 and FSM in IDLE. Reset mid-access drops mem_en immediately; the access is lost and neither done nor err fires.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, dmem_r or dmem_w high: validate the request in the same cycle.
  - err if both strobes are high.
  - err if store format is 11 (stores only).
  - err if misaligned: word with addr[1:0]!=0, or half with addr[0]!=0. Loads are always word reads, so a load with addr[1:0]!=0 is legal.
  - err if out of range: addr < BASE_ADDR or addr >= BASE_ADDR + 4*2^DEPTH_LOG2.
  - Rejected request: err pulses the next cycle, state stays IDLE, nothing latched, detail_pos unchanged.
  - Accepted request: latch address, data, format and direction; detail_pos <= addr[1:0]; next cycle go to ACCESS with mem_en=1 and busy=1.
- Byte enables for stores:
  - word: 1111.
  - half: addr[1]=0 gives 0011, addr[1]=1 gives 1100.
  - byte: 0001 << addr[1:0].
  - loads: 1111, mem_we=0.
- mem_wdata lane replication:
  - word: as given.
  - half: {w_data[15:0], w_data[15:0]}.
  - byte: {4{w_data[7:0]}}.
- ACCESS: mem_en, mem_we, mem_addr, mem_be and mem_wdata are held stable until mem_ack. The wait counter starts at 0 on entry and increments each cycle without ack.
  - mem_ack: a read captures mem_rdata into dmem_data; go to RESP with mem_en=0.
  - Counter reaches TIMEOUT-1 without ack: drop mem_en, pulse err, return to IDLE, dmem_data unchanged.
  - mem_ack in the same cycle as the timeout: ack wins.
- RESP: done=1 for one cycle, busy=0, then IDLE. Latency from acceptance to done is at least 3 cycles with a zero-wait RAM (accept, ACCESS with ack, RESP).
- busy is high in ACCESS only. Strobes seen while not in IDLE are ignored; the controller holds its strobe until done or err.
- dmem_data and detail_pos hold their values until the next successful read or accepted request, so the MDR may sample at any time after done.

Decomposition:
- Shared package dmem_pkg holds:
  - FSM state encoding.
  - store-format constants FMT_WORD=2'b00, FMT_HALF=2'b01, FMT_BYTE=2'b10.
  - function be_gen(fmt, off) -> [3:0].
  - function lane_rep(fmt, data) -> [31:0].
- One sub-module: dmem_req_check, purely combinational. Inputs: addr, fmt, r, w. Outputs: ok, word index. Keeps range and alignment logic testable in isolation.

Test Plan:
- Word store 0xCAFEBABE at 0x1001_0008, ack after 2 wait cycles -> mem_addr=2, mem_be=1111, mem_we=1, done 1 cycle after ack, err=0.
- Byte store 0x000000A5 at 0x1001_0003 -> mem_be=1000, mem_wdata=0xA5A5A5A5. Then load from 0x1001_0003 with mem_rdata=0xA5112233 -> dmem_data=0xA5112233, detail_pos=11.
- Half store at 0x1001_0001 -> err pulse, no mem_en. Word store at 0x1000_FFFC -> err. Load with both dmem_r and dmem_w high -> err.
- Load at 0x1001_0010 with no ack, TIMEOUT=16 -> mem_en high 16 cycles, then err, busy=0, dmem_data keeps its prior value.
- Ack in the exact timeout cycle -> done, no err. New strobe asserted while busy -> ignored, no second mem_en.
- rstn low during ACCESS -> mem_en, busy, done, err and dmem_data all 0 asynchronously; the next request after release is handled normally.
